ahb_arbiter_param: RTL and testbench
====================================

Name: ahb_arbiter_param

Overview:
- Parametrised AHB multi-master arbiter; successor to the fixed 9-master arbiter.
- Selectable fixed-priority or round-robin policy, burst-aware grant hold (INCR4/8/16, WRAP4/8/16), locked-transfer hold and a parametrised default master.
- Muxes the granted master's address/control (address phase) and the owning master's write data (data phase) onto the shared slave-side bus.
- Slave decode and read-data return stay in the separate decoder/mux block.

Parameters:
- NUM_MASTERS, 4, number of masters (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ARB_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round robin.
- DEF_MASTER, 0, master granted when no request is pending.
- ID_W, $clog2(NUM_MASTERS), width of master index.

Ports:
- hclk  in  1  bus clock
- hreset  in  1  synchronous reset, active-high
- m_busreq  in  NUM_MASTERS  bus requests
- m_hlock  in  NUM_MASTERS  locked-access requests
- m_haddr  in  ADDR_W*NUM_MASTERS  flattened addresses, master i at [i*ADDR_W +: ADDR_W]
- m_htrans  in  2*NUM_MASTERS  flattened HTRANS
- m_hburst  in  3*NUM_MASTERS  flattened HBURST
- m_hwrite  in  NUM_MASTERS  HWRITE per master
- m_hsize  in  3*NUM_MASTERS  flattened HSIZE
- m_hwdata  in  DATA_W*NUM_MASTERS  flattened write data
- s_hready  in  1  combined HREADY from the slave mux
- hgrant  out  NUM_MASTERS  one-hot grant
- s_hmaster  out  ID_W  address-phase owner
- s_hmaster_data  out  ID_W  data-phase owner
- s_hmastlock  out  1  current address-phase transfer is locked
- s_haddr  out  ADDR_W  muxed address
- s_htrans  out  2  muxed HTRANS
- s_hburst  out  3  muxed HBURST
- s_hwrite  out  1  muxed HWRITE
- s_hsize  out  3  muxed HSIZE
- s_hwdata  out  DATA_W  muxed write data, selected by s_hmaster_data

Behaviour:
- Reset (hreset=1 at posedge): hgrant = one-hot(DEF_MASTER), s_hmaster = s_hmaster_data = DEF_MASTER, s_hmastlock = 0, beat counter = 0, FSM = ARB, rr pointer = DEF_MASTER. Reset mid-burst abandons the burst immediately.
- Address/control outputs are combinational muxes indexed by s_hmaster. s_hwdata is a combinational mux indexed by s_hmaster_data.
- Ownership pipeline (only when s_hready=1):
  - s_hmaster <= index(hgrant)
  - s_hmaster_data <= s_hmaster
  - s_hmastlock <= m_hlock[index(hgrant)]
  - s_hready=0 freezes all three.
- Arbitration (next_grant):
  - ARB_MODE=0: lowest-index requester.
  - ARB_MODE=1: first requester searching from (last_owner+1) mod NUM_MASTERS upward, with wrap.
  - No requester: DEF_MASTER.
  - hgrant updates at posedge only when arb_ok=1 and s_hready=1; otherwise holds.
- FSM states:
  - ARB: arb_ok=1.
    - Owner's accepted address phase (s_hready=1, s_htrans=NONSEQ) with s_hburst ∈ {INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16}: counter = beats-1 (3/7/15), go to BURST.
    - If s_hmastlock=1 or m_hlock[owner]=1 while owner requests: go to LOCK.
    - SINGLE/INCR stay in ARB.
  - BURST: arb_ok=0.
    - Counter decrements on each accepted SEQ.
    - On the accepted beat that brings the counter to 1, arb_ok=1, so the grant moves during the last beat (AHB early handover). Then return to ARB.
    - Owner drives IDLE or NONSEQ before completion: burst terminated early, counter cleared, go to ARB (NONSEQ re-evaluated as a new burst start).
    - BUSY: counter holds.
  - LOCK: arb_ok=0 while m_hlock[owner]=1. Exit to ARB the cycle after m_hlock[owner] drops with s_hready=1. One extra locked-owner cycle always follows, so the IDLE after a locked sequence stays with the owner.
- Simultaneous requests: policy order decides. Owner dropping m_busreq mid-burst does not shorten the burst.
- Round-robin pointer updates to the new owner on every grant change.
- Out-of-range DEF_MASTER is a static elaboration error.

Decomposition:
- Shared package ahb_pkg:
  - htrans_e (IDLE, BUSY, NONSEQ, SEQ)
  - hburst_e (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16)
  - function burst_beats(hburst_e)
  - arb_state_e (ARB, BURST, LOCK)
- Sub-module ahb_arb_sel: combinational priority/round-robin selector (req, pointer, mode → index, valid).

Test Plan:
- Reset: hreset=1 two cycles, DEF_MASTER=0, no requests → hgrant=4'b0001, s_hmaster=0, s_hmastlock=0.
- Fixed priority: ARB_MODE=0, m_busreq=4'b1010, SINGLE transfers → master 1 granted continuously; master 3 granted only after m_busreq[1] drops.
- Round robin: ARB_MODE=1, m_busreq=4'b1111, SINGLE transfers, s_hready=1 → grants cycle 0,1,2,3,0 one per cycle.
- INCR8 hold: master 2 issues INCR8, master 0 requests at beat 2 → grant stays 2 until the 8th beat address phase, then hgrant=4'b0001. s_hmaster_data lags s_hmaster by one ready cycle.
- Wait states: s_hready=0 for 3 cycles during beat 4 of INCR4 → hgrant, s_hmaster and counter frozen; s_hwdata keeps beat-3 data.
- Locked: master 1 holds m_hlock=1 across 3 SINGLEs with master 0 requesting → s_hmastlock=1 for those transfers; master 0 granted one cycle after m_hlock[1] falls.
- Early termination: master 3 issues WRAP4, drives IDLE after beat 2 → FSM returns to ARB and the grant passes to the next requester.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers for the arbiter slice.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ARB,
    BURST,
    LOCK
  } arb_state_e;

  // Fixed-length bursts return their beat count; SINGLE/INCR return 0.
  function automatic logic [4:0] burst_beats(hburst_e b);
    case (b)
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_sel.sv
// Combinational requester selector: lowest index first, or round robin after ptr.
module ahb_arb_sel #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        ptr,
  input  logic                   mode,
  output logic [ID_W-1:0]        idx,
  output logic                   valid
);

  localparam int unsigned N = NUM_MASTERS;

  int unsigned cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = mode ? (32'(ptr) + 32'd1 + k) % N : k;
      if (!valid && req[cand[ID_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB arbiter: policy-selectable grant, burst/lock hold and
// address/data-phase muxing of the owning master onto the slave-side bus.
module ahb_arbiter_param import ahb_pkg::*; #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = 1,
  parameter int DEF_MASTER  = 0,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic [NUM_MASTERS-1:0]        m_busreq,
  input  logic [NUM_MASTERS-1:0]        m_hlock,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_haddr,
  input  logic [2*NUM_MASTERS-1:0]      m_htrans,
  input  logic [3*NUM_MASTERS-1:0]      m_hburst,
  input  logic [NUM_MASTERS-1:0]        m_hwrite,
  input  logic [3*NUM_MASTERS-1:0]      m_hsize,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_hwdata,
  input  logic                          s_hready,
  output logic [NUM_MASTERS-1:0]        hgrant,
  output logic [ID_W-1:0]               s_hmaster,
  output logic [ID_W-1:0]               s_hmaster_data,
  output logic                          s_hmastlock,
  output logic [ADDR_W-1:0]             s_haddr,
  output logic [1:0]                    s_htrans,
  output logic [2:0]                    s_hburst,
  output logic                          s_hwrite,
  output logic [2:0]                    s_hsize,
  output logic [DATA_W-1:0]             s_hwdata
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || DEF_MASTER < 0 || DEF_MASTER >= NUM_MASTERS)
  begin : g_param_err
    $error("ahb_arbiter_param: NUM_MASTERS or DEF_MASTER out of range");
  end

  localparam logic [ID_W-1:0] DEF_ID = ID_W'(DEF_MASTER);

  logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
  logic [1:0]        trans_arr [NUM_MASTERS];
  logic [2:0]        burst_arr [NUM_MASTERS];
  logic [2:0]        size_arr  [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_split
    assign addr_arr[i]  = m_haddr[i*ADDR_W +: ADDR_W];
    assign trans_arr[i] = m_htrans[i*2 +: 2];
    assign burst_arr[i] = m_hburst[i*3 +: 3];
    assign size_arr[i]  = m_hsize[i*3 +: 3];
    assign wdata_arr[i] = m_hwdata[i*DATA_W +: DATA_W];
  end

  assign s_haddr  = addr_arr[s_hmaster];
  assign s_htrans = trans_arr[s_hmaster];
  assign s_hburst = burst_arr[s_hmaster];
  assign s_hwrite = m_hwrite[s_hmaster];
  assign s_hsize  = size_arr[s_hmaster];
  assign s_hwdata = wdata_arr[s_hmaster_data];

  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] sel_idx;
  logic [ID_W-1:0] next_idx;
  logic            sel_valid;
  logic            arb_ok;
  logic            lock_req;
  logic [3:0]      cnt;
  logic [4:0]      beats;
  htrans_e         trans;
  arb_state_e      state;

  ahb_arb_sel #(
    .NUM_MASTERS(NUM_MASTERS),
    .ID_W       (ID_W)
  ) u_sel (
    .req  (m_busreq),
    .ptr  (rr_ptr),
    .mode (ARB_MODE != 0),
    .idx  (sel_idx),
    .valid(sel_valid)
  );

  assign next_idx = sel_valid ? sel_idx : DEF_ID;

  always_comb begin
    hgrant            = '0;
    hgrant[grant_idx] = 1'b1;
  end

  always_comb begin
    trans    = htrans_e'(s_htrans);
    beats    = burst_beats(hburst_e'(s_hburst));
    lock_req = m_busreq[s_hmaster] && (s_hmastlock || m_hlock[s_hmaster]);
    case (state)
      ARB:     arb_ok = 1'b1;
      // Releasing on the beat that leaves one beat outstanding lets the next
      // owner's grant line up with the final address phase.
      BURST:   arb_ok = (trans == SEQ) && (cnt == 4'd2);
      default: arb_ok = 1'b0;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      grant_idx      <= DEF_ID;
      rr_ptr         <= DEF_ID;
      s_hmaster      <= DEF_ID;
      s_hmaster_data <= DEF_ID;
      s_hmastlock    <= 1'b0;
      cnt            <= '0;
      state          <= ARB;
    end else if (s_hready) begin
      s_hmaster      <= grant_idx;
      s_hmaster_data <= s_hmaster;
      s_hmastlock    <= m_hlock[grant_idx];
      if (arb_ok) begin
        grant_idx <= next_idx;
        if (next_idx != grant_idx) rr_ptr <= next_idx;
      end
      case (state)
        ARB: begin
          if (trans == NONSEQ && beats != 5'd0) begin
            cnt   <= 4'(beats - 5'd1);
            state <= BURST;
          end else begin
            cnt <= '0;
            if (lock_req) state <= LOCK;
          end
        end
        BURST: begin
          unique case (trans)
            SEQ: begin
              cnt <= cnt - 4'd1;
              if (cnt == 4'd2) state <= ARB;
            end
            NONSEQ: begin
              if (beats != 5'd0) begin
                cnt <= 4'(beats - 5'd1);
              end else begin
                cnt   <= '0;
                state <= ARB;
              end
            end
            IDLE: begin
              cnt   <= '0;
              state <= ARB;
            end
            BUSY: ;
          endcase
        end
        LOCK: begin
          if (!m_hlock[s_hmaster]) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Directed bench: vector table for grant policies plus hand sequences for bursts, waits and locks.
module tb_ahb_arbiter_param;
  import ahb_pkg::*;

  logic         hclk = 1'b0;
  logic         hreset;
  logic [3:0]   m_busreq, m_hlock, m_hwrite;
  logic [127:0] m_haddr, m_hwdata;
  logic [7:0]   m_htrans;
  logic [11:0]  m_hburst, m_hsize;
  logic         s_hready;

  logic [3:0]  fp_hgrant, rr_hgrant;
  logic [1:0]  fp_hmaster, rr_hmaster, fp_hmaster_data, rr_hmaster_data;
  logic        fp_hmastlock, rr_hmastlock, fp_hwrite, rr_hwrite;
  logic [31:0] fp_haddr, rr_haddr, fp_hwdata, rr_hwdata;
  logic [1:0]  fp_htrans, rr_htrans;
  logic [2:0]  fp_hburst, rr_hburst, fp_hsize, rr_hsize;

  int passed = 0;
  int total  = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter_param #(
    .NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .DEF_MASTER(0)
  ) dut_fp (
    .hclk(hclk), .hreset(hreset), .m_busreq(m_busreq), .m_hlock(m_hlock),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hburst(m_hburst), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hwdata(m_hwdata), .s_hready(s_hready),
    .hgrant(fp_hgrant), .s_hmaster(fp_hmaster), .s_hmaster_data(fp_hmaster_data),
    .s_hmastlock(fp_hmastlock), .s_haddr(fp_haddr), .s_htrans(fp_htrans),
    .s_hburst(fp_hburst), .s_hwrite(fp_hwrite), .s_hsize(fp_hsize), .s_hwdata(fp_hwdata)
  );

  ahb_arbiter_param #(
    .NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .DEF_MASTER(0)
  ) dut_rr (
    .hclk(hclk), .hreset(hreset), .m_busreq(m_busreq), .m_hlock(m_hlock),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hburst(m_hburst), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hwdata(m_hwdata), .s_hready(s_hready),
    .hgrant(rr_hgrant), .s_hmaster(rr_hmaster), .s_hmaster_data(rr_hmaster_data),
    .s_hmastlock(rr_hmastlock), .s_haddr(rr_haddr), .s_htrans(rr_htrans),
    .s_hburst(rr_hburst), .s_hwrite(rr_hwrite), .s_hsize(rr_hsize), .s_hwdata(rr_hwdata)
  );

  typedef struct {
    logic       rst;
    logic       use_rr;
    logic [3:0] busreq;
    logic [3:0] exp_grant;
    logic [1:0] exp_master;
    logic [1:0] exp_dmaster;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [31:0] exp_addr(input int m);
    return 32'hA000_0000 + 32'(m) * 32'h100;
  endfunction

  function automatic logic [31:0] exp_data(input int m);
    return 32'hD000_0000 + 32'(m);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_trans(input int m, input logic [1:0] t, input logic [2:0] b);
    m_htrans[m*2 +: 2] = t;
    m_hburst[m*3 +: 3] = b;
  endtask

  task automatic all_trans(input logic [1:0] t, input logic [2:0] b);
    for (int m = 0; m < 4; m++) set_trans(m, t, b);
  endtask

  task automatic do_reset();
    hreset   = 1'b1;
    m_busreq = '0;
    m_hlock  = '0;
    s_hready = 1'b1;
    all_trans(IDLE, SINGLE);
    step();
    step();
    hreset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  g;
    logic [1:0]  hm, hmd;
    logic        lk, wr;
    logic [31:0] ad, wd;
    logic [1:0]  tr;
    logic [2:0]  bu, sz;

    hreset   = 1'b1;
    m_busreq = '0;
    m_hlock  = '0;
    s_hready = 1'b1;
    m_hwrite = 4'b0101;
    for (int m = 0; m < 4; m++) begin
      m_haddr[m*32 +: 32] = exp_addr(m);
      m_hwdata[m*32 +: 32] = exp_data(m);
      m_hsize[m*3 +: 3]   = 3'd2;
    end
    all_trans(NONSEQ, SINGLE);

    // rst, use_rr, busreq, grant, s_hmaster, s_hmaster_data
    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 2'd0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 2'd0, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 4'b1010, 4'b0010, 2'd0, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 4'b1010, 4'b0010, 2'd1, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 4'b1010, 4'b0010, 2'd1, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 4'b1000, 4'b1000, 2'd1, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 4'b1000, 4'b1000, 2'd3, 2'd1};
    vecs[7]  = '{1'b1, 1'b1, 4'b1111, 4'b0001, 2'd0, 2'd0};
    vecs[8]  = '{1'b0, 1'b1, 4'b1111, 4'b0010, 2'd0, 2'd0};
    vecs[9]  = '{1'b0, 1'b1, 4'b1111, 4'b0100, 2'd1, 2'd0};
    vecs[10] = '{1'b0, 1'b1, 4'b1111, 4'b1000, 2'd2, 2'd1};
    vecs[11] = '{1'b0, 1'b1, 4'b1111, 4'b0001, 2'd3, 2'd2};
    vecs[12] = '{1'b0, 1'b1, 4'b1111, 4'b0010, 2'd0, 2'd3};
    vecs[13] = '{1'b0, 1'b1, 4'b0000, 4'b0001, 2'd1, 2'd0};

    for (int i = 0; i < 14; i++) begin
      hreset   = vecs[i].rst;
      m_busreq = vecs[i].busreq;
      step();
      g   = vecs[i].use_rr ? rr_hgrant       : fp_hgrant;
      hm  = vecs[i].use_rr ? rr_hmaster      : fp_hmaster;
      hmd = vecs[i].use_rr ? rr_hmaster_data : fp_hmaster_data;
      lk  = vecs[i].use_rr ? rr_hmastlock    : fp_hmastlock;
      ad  = vecs[i].use_rr ? rr_haddr        : fp_haddr;
      wd  = vecs[i].use_rr ? rr_hwdata       : fp_hwdata;
      tr  = vecs[i].use_rr ? rr_htrans       : fp_htrans;
      bu  = vecs[i].use_rr ? rr_hburst       : fp_hburst;
      wr  = vecs[i].use_rr ? rr_hwrite       : fp_hwrite;
      sz  = vecs[i].use_rr ? rr_hsize        : fp_hsize;
      chk($sformatf("vec%0d hgrant", i), 32'(g), 32'(vecs[i].exp_grant));
      chk($sformatf("vec%0d s_hmaster", i), 32'(hm), 32'(vecs[i].exp_master));
      chk($sformatf("vec%0d s_hmaster_data", i), 32'(hmd), 32'(vecs[i].exp_dmaster));
      chk($sformatf("vec%0d s_hmastlock", i), 32'(lk), 32'd0);
      chk($sformatf("vec%0d s_haddr", i), ad, exp_addr(int'(vecs[i].exp_master)));
      chk($sformatf("vec%0d s_hwdata", i), wd, exp_data(int'(vecs[i].exp_dmaster)));
      chk($sformatf("vec%0d ctrl", i), 32'({tr, bu, wr, sz}),
          32'({2'b10, 3'b000, m_hwrite[vecs[i].exp_master], 3'd2}));
    end

    // INCR8 from master 2; master 0 arrives at beat 2 and must wait for the last beat.
    do_reset();
    m_busreq = 4'b0100;
    set_trans(2, NONSEQ, INCR8);
    step();
    chk("incr8 grant e1", 32'(fp_hgrant), 32'b0100);
    chk("incr8 hmaster e1", 32'(fp_hmaster), 32'd0);
    step();
    chk("incr8 hmaster e2", 32'(fp_hmaster), 32'd2);
    chk("incr8 hmaster_data e2", 32'(fp_hmaster_data), 32'd0);
    chk("incr8 haddr", fp_haddr, exp_addr(2));
    step();
    chk("incr8 hmaster_data e3", 32'(fp_hmaster_data), 32'd2);
    set_trans(2, SEQ, INCR8);
    m_busreq = 4'b0101;
    for (int b = 2; b <= 6; b++) begin
      step();
      chk($sformatf("incr8 hold beat%0d", b), 32'(fp_hgrant), 32'b0100);
    end
    step();
    chk("incr8 handover grant", 32'(fp_hgrant), 32'b0001);
    chk("incr8 last beat owner", 32'(fp_hmaster), 32'd2);
    step();
    chk("incr8 new owner", 32'(fp_hmaster), 32'd0);
    chk("incr8 data owner", 32'(fp_hmaster_data), 32'd2);
    set_trans(2, IDLE, SINGLE);

    // Locked SINGLEs from master 1 while master 0 requests.
    do_reset();
    m_busreq = 4'b0010;
    m_hlock  = 4'b0010;
    set_trans(1, NONSEQ, SINGLE);
    step();
    chk("lock grant e1", 32'(fp_hgrant), 32'b0010);
    step();
    chk("lock T1 owner", 32'(fp_hmaster), 32'd1);
    chk("lock T1 mastlock", 32'(fp_hmastlock), 32'd1);
    step();
    chk("lock T2 mastlock", 32'(fp_hmastlock), 32'd1);
    m_busreq = 4'b0011;
    step();
    chk("lock T3 mastlock", 32'(fp_hmastlock), 32'd1);
    chk("lock T3 grant", 32'(fp_hgrant), 32'b0010);
    m_hlock = 4'b0000;
    step();
    chk("lock extra cycle grant", 32'(fp_hgrant), 32'b0010);
    chk("lock extra cycle owner", 32'(fp_hmaster), 32'd1);
    chk("lock released mastlock", 32'(fp_hmastlock), 32'd0);
    set_trans(1, IDLE, SINGLE);
    step();
    chk("lock handover grant", 32'(fp_hgrant), 32'b0001);
    chk("lock idle owner", 32'(fp_hmaster), 32'd1);
    step();
    chk("lock new owner", 32'(fp_hmaster), 32'd0);

    // WRAP4 from master 3 cut short by IDLE after beat 2.
    do_reset();
    m_busreq = 4'b1000;
    set_trans(3, NONSEQ, WRAP4);
    step();
    chk("term grant e1", 32'(fp_hgrant), 32'b1000);
    step();
    chk("term owner", 32'(fp_hmaster), 32'd3);
    step();
    set_trans(3, SEQ, WRAP4);
    m_busreq = 4'b1010;
    step();
    chk("term hold beat2", 32'(fp_hgrant), 32'b1000);
    set_trans(3, IDLE, SINGLE);
    step();
    chk("term idle cycle grant", 32'(fp_hgrant), 32'b1000);
    step();
    chk("term handover grant", 32'(fp_hgrant), 32'b0010);
    step();
    chk("term new owner", 32'(fp_hmaster), 32'd1);

    // INCR4 from master 1 with three wait states during beat 4.
    do_reset();
    m_busreq = 4'b0110;
    set_trans(1, NONSEQ, INCR4);
    step();
    chk("wait grant e1", 32'(fp_hgrant), 32'b0010);
    step();
    chk("wait owner", 32'(fp_hmaster), 32'd1);
    step();
    set_trans(1, SEQ, INCR4);
    m_busreq = 4'b0100;
    step();
    chk("wait hold beat2", 32'(fp_hgrant), 32'b0010);
    step();
    chk("wait handover grant", 32'(fp_hgrant), 32'b0100);
    m_hwdata[32 +: 32] = 32'hB3B3_0003;
    s_hready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      step();
      chk($sformatf("wait%0d grant", w), 32'(fp_hgrant), 32'b0100);
      chk($sformatf("wait%0d owner", w), 32'(fp_hmaster), 32'd1);
      chk($sformatf("wait%0d data owner", w), 32'(fp_hmaster_data), 32'd1);
      chk($sformatf("wait%0d hwdata", w), fp_hwdata, 32'hB3B3_0003);
    end
    s_hready = 1'b1;
    step();
    chk("wait release owner", 32'(fp_hmaster), 32'd2);
    chk("wait release data owner", 32'(fp_hmaster_data), 32'd1);
    chk("wait release grant", 32'(fp_hgrant), 32'b0100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
